// File: rtl/fib_batch_seq.sv
// Batch sequencer for the fib core: turns one (start, count) command into a run of
// fib parameter transfers and forwards each result downstream with its index and a
// last flag. Each fib handshake is supervised by a timeout that abandons the batch.
module fib_batch_seq #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned TIMEOUT     = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  cmd_start,
    input  logic [COUNT_WIDTH-1:0] cmd_count,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    output logic [DATA_WIDTH-1:0]  fib_param_data,
    output logic                   fib_param_en,
    input  logic                   fib_param_ack,
    input  logic [DATA_WIDTH-1:0]  fib_result_data,
    input  logic                   fib_result_en,
    output logic                   fib_result_ack,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [DATA_WIDTH-1:0]  out_index,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   err
);

    localparam int unsigned TmoW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StSend, StRecv, StEmit} state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  n_q, n_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic [TmoW-1:0]        tmo_q, tmo_d;
    logic                   err_q, err_d;
    logic                   param_en_q, param_en_d;
    logic                   result_ack_q, result_ack_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0]  out_index_q, out_index_d;
    logic                   out_last_q, out_last_d;
    logic                   out_valid_q, out_valid_d;

    logic cmd_acc, param_xfer, result_xfer, out_xfer, last_item, tmo_fire, in_wait;

    assign cmd_acc     = cmd_valid && (state_q == StIdle);
    assign param_xfer  = param_en_q && fib_param_ack;
    assign result_xfer = result_ack_q && fib_result_en;
    assign out_xfer    = out_valid_q && out_ready;
    assign last_item   = (rem_q == COUNT_WIDTH'(1));
    assign in_wait     = (state_q == StSend) || (state_q == StRecv);

    // Expiry is taken on the cycle the counter would reach zero, so a handshake
    // landing on that same edge still wins.
    assign tmo_fire = (TIMEOUT != 0) && (tmo_q == TmoW'(1)) &&
                      (((state_q == StSend) && !param_xfer) ||
                       ((state_q == StRecv) && !result_xfer));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_acc && (cmd_count != '0)) state_d = StSend;
            end
            StSend: begin
                if (param_xfer)    state_d = StRecv;
                else if (tmo_fire) state_d = StIdle;
            end
            StRecv: begin
                if (result_xfer)   state_d = StEmit;
                else if (tmo_fire) state_d = StIdle;
            end
            StEmit: begin
                if (out_xfer) state_d = last_item ? StIdle : StSend;
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and batch datapath
    always_comb begin
        n_d         = n_q;
        rem_d       = rem_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        // Handshake strobes follow the upcoming state so they are registered yet
        // line up exactly with SEND / RECV.
        param_en_d   = (state_d == StSend);
        result_ack_d = (state_d == StRecv);

        if (cmd_acc) begin
            err_d = 1'b0;
            if (cmd_count != '0) begin
                n_d   = cmd_start;
                rem_d = cmd_count;
            end
        end

        if (tmo_fire) err_d = 1'b1;

        if (((state_d == StSend) || (state_d == StRecv)) && (state_d != state_q)) begin
            tmo_d = TmoW'(TIMEOUT);
        end else if (in_wait && (tmo_q != '0)) begin
            tmo_d = tmo_q - 1'b1;
        end

        if (result_xfer) begin
            out_data_d  = fib_result_data;
            out_index_d = n_q;
            out_last_d  = last_item;
            out_valid_d = 1'b1;
        end

        if (out_xfer) begin
            out_valid_d = 1'b0;
            if (!last_item) begin
                n_d   = n_q + 1'b1;
                rem_d = rem_q - 1'b1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q          <= '0;
            rem_q        <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            param_en_q   <= 1'b0;
            result_ack_q <= 1'b0;
            out_data_q   <= '0;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            n_q          <= n_d;
            rem_q        <= rem_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            param_en_q   <= param_en_d;
            result_ack_q <= result_ack_d;
            out_data_q   <= out_data_d;
            out_index_q  <= out_index_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign cmd_ready      = (state_q == StIdle);
    assign busy           = (state_q != StIdle);
    assign err            = err_q;
    assign fib_param_data = n_q;
    assign fib_param_en   = param_en_q;
    assign fib_result_ack = result_ack_q;
    assign out_data       = out_data_q;
    assign out_index      = out_index_q;
    assign out_last       = out_last_q;
    assign out_valid      = out_valid_q;

endmodule

// File: tb/tb_fib_batch_seq.sv
// Directed bench for fib_batch_seq: a behavioural fib stub on the core side and
// table-driven batches with hand-computed results on the output side.
module tb_fib_batch_seq;

    logic        clk;
    logic        rst_n;
    logic [31:0] cmd_start;
    logic [15:0] cmd_count;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] fib_param_data;
    logic        fib_param_en;
    logic        fib_param_ack;
    logic [31:0] fib_result_data;
    logic        fib_result_en;
    logic        fib_result_ack;
    logic [31:0] out_data;
    logic [31:0] out_index;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        err;

    fib_batch_seq #(
        .DATA_WIDTH (32),
        .COUNT_WIDTH(16),
        .TIMEOUT    (1000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_start      (cmd_start),
        .cmd_count      (cmd_count),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .fib_param_data (fib_param_data),
        .fib_param_en   (fib_param_en),
        .fib_param_ack  (fib_param_ack),
        .fib_result_data(fib_result_data),
        .fib_result_en  (fib_result_en),
        .fib_result_ack (fib_result_ack),
        .out_data       (out_data),
        .out_index      (out_index),
        .out_last       (out_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] start;
        logic [15:0] count;
        bit          stall;
        int          first;
    } batch_t;

    typedef struct {
        logic [31:0] index;
        logic [31:0] data;
        logic        last;
    } item_t;

    batch_t tbl[5];
    item_t  items[14];

    int n_checks = 0;
    int n_fail   = 0;
    bit stub_dead = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fib_f(input logic [31:0] n);
        logic [31:0] a, b, t;
        a = 0;
        b = 1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // fib core stub: acks a parameter one cycle after it is offered, answers
    // two cycles later, holds the result until the sequencer takes it.
    initial begin
        logic [31:0] sn;
        fib_param_ack   = 1'b0;
        fib_result_en   = 1'b0;
        fib_result_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n && !stub_dead && fib_param_en) begin
                fib_param_ack = 1'b1;
                sn = fib_param_data;
                @(negedge clk);
                fib_param_ack = 1'b0;
                repeat (2) @(negedge clk);
                fib_result_data = fib_f(sn);
                fib_result_en   = 1'b1;
                while (!fib_result_ack && rst_n) @(negedge clk);
                @(negedge clk);
                fib_result_en = 1'b0;
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, " cmd_ready"}, cmd_ready, 1);
        chk({tag, " fib_param_en"}, fib_param_en, 0);
        chk({tag, " fib_param_data"}, fib_param_data, 0);
        chk({tag, " fib_result_ack"}, fib_result_ack, 0);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " out_data"}, out_data, 0);
        chk({tag, " out_index"}, out_index, 0);
        chk({tag, " out_last"}, out_last, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " err"}, err, 0);
    endtask

    task automatic run_batch(input int b);
        int          item, cyc, last_item;
        bit          done, hold_bad, overlap_bad, prev_valid;
        logic [31:0] prev_data, prev_index;
        logic        prev_last;
        string       tag;
        tag = $sformatf("batch%0d", b);
        item = tbl[b].first;
        last_item = tbl[b].first + int'(tbl[b].count);
        done = 0; hold_bad = 0; overlap_bad = 0; prev_valid = 0;
        prev_data = '0; prev_index = '0; prev_last = 1'b0;
        chk({tag, " cmd_ready idle"}, cmd_ready, 1);
        cmd_start = tbl[b].start;
        cmd_count = tbl[b].count;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0;
        while (!done && cyc < 2000) begin
            if (fib_param_en && out_valid) overlap_bad = 1;
            if (prev_valid && (!out_valid || out_data != prev_data ||
                               out_index != prev_index || out_last != prev_last))
                hold_bad = 1;
            out_ready = tbl[b].stall ? (cyc % 3 == 0) : 1'b1;
            if (out_valid && out_ready) begin
                chk($sformatf("%s item%0d index", tag, item), out_index, items[item].index);
                chk($sformatf("%s item%0d data", tag, item), out_data, items[item].data);
                chk($sformatf("%s item%0d last", tag, item), out_last, items[item].last);
                item++;
                if (item == last_item) done = 1;
                prev_valid = 0;
            end else begin
                prev_valid = out_valid;
                prev_data  = out_data;
                prev_index = out_index;
                prev_last  = out_last;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk({tag, " all items within budget"}, done, 1);
        chk({tag, " outputs held while stalled"}, hold_bad, 0);
        chk({tag, " no param while output pending"}, overlap_bad, 0);
        chk({tag, " cmd_ready after batch"}, cmd_ready, 1);
        chk({tag, " busy after batch"}, busy, 0);
        chk({tag, " out_valid after batch"}, out_valid, 0);
        chk({tag, " err after batch"}, err, 0);
    endtask

    initial begin
        int cyc, en_cycles;
        bit bad;

        tbl[0] = '{start: 0,  count: 7, stall: 0, first: 0};
        tbl[1] = '{start: 10, count: 1, stall: 0, first: 7};
        tbl[2] = '{start: 20, count: 3, stall: 1, first: 8};
        tbl[3] = '{start: 4,  count: 2, stall: 0, first: 11};
        tbl[4] = '{start: 10, count: 1, stall: 1, first: 13};

        items[0]  = '{index: 0,  data: 0,     last: 0};
        items[1]  = '{index: 1,  data: 1,     last: 0};
        items[2]  = '{index: 2,  data: 1,     last: 0};
        items[3]  = '{index: 3,  data: 2,     last: 0};
        items[4]  = '{index: 4,  data: 3,     last: 0};
        items[5]  = '{index: 5,  data: 5,     last: 0};
        items[6]  = '{index: 6,  data: 8,     last: 1};
        items[7]  = '{index: 10, data: 55,    last: 1};
        items[8]  = '{index: 20, data: 6765,  last: 0};
        items[9]  = '{index: 21, data: 10946, last: 0};
        items[10] = '{index: 22, data: 17711, last: 1};
        items[11] = '{index: 4,  data: 3,     last: 0};
        items[12] = '{index: 5,  data: 5,     last: 1};
        items[13] = '{index: 10, data: 55,    last: 1};

        rst_n = 1'b0;
        cmd_start = '0;
        cmd_count = '0;
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-length command: accepted in one cycle, nothing issued.
        chk("count0 cmd_ready", cmd_ready, 1);
        cmd_start = 32'd5;
        cmd_count = 16'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (fib_param_en || out_valid || busy) bad = 1;
            @(negedge clk);
        end
        chk("count0 stays quiet", bad, 0);
        chk("count0 cmd_ready after", cmd_ready, 1);

        for (int b = 0; b < 3; b++) run_batch(b);

        // Parameter never acknowledged: timeout after exactly 1000 cycles.
        stub_dead = 1'b1;
        cmd_start = 32'd3;
        cmd_count = 16'd2;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        en_cycles = 0;
        cyc = 0;
        bad = 0;
        while (fib_param_en && cyc < 1100) begin
            en_cycles++;
            if (out_valid) bad = 1;
            @(negedge clk);
            cyc++;
        end
        chk("timeout param_en cycles", en_cycles, 1000);
        chk("timeout no output", bad | out_valid, 0);
        chk("timeout err set", err, 1);
        chk("timeout back to idle", cmd_ready, 1);
        chk("timeout busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("timeout err sticky", err, 1);
        stub_dead = 1'b0;
        run_batch(4);

        // Reset while an output item is pending.
        cmd_start = 32'd4;
        cmd_count = 16'd2;
        cmd_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("pre-reset out_valid", out_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("mid-batch reset");
        rst_n = 1'b1;
        @(negedge clk);
        run_batch(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fib_batch_seq.md
# fib_batch_seq

Batch sequencer that wraps the `fib` core. It accepts one command (first index `n`, item count) and issues one `fib` parameter transfer per index. It collects each `fib` result and forwards it downstream as a valid/ready stream tagged with its index and a last flag. It sits between the command front end and `fib`, driving `fib`'s parameter channel and consuming its result channel, and supervises both handshakes with a per-transfer timeout.

## Interface

- `DATA_WIDTH`, 32, width of `n` and of results; must match `fib`.
- `COUNT_WIDTH`, 16, width of the batch item count.
- `TIMEOUT`, 1000, maximum cycles to wait on any one `fib` handshake; 0 disables the timeout.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_start`  in  DATA_WIDTH  first index of the batch.
- `cmd_count`  in  COUNT_WIDTH  number of items in the batch.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer idle; command accepted when `cmd_valid && cmd_ready`.
- `fib_param_data`  out  DATA_WIDTH  index `n` to `fib`.
- `fib_param_en`  out  1  parameter offered to `fib`.
- `fib_param_ack`  in  1  `fib` accepts the parameter.
- `fib_result_data`  in  DATA_WIDTH  result from `fib`.
- `fib_result_en`  in  1  result valid from `fib`.
- `fib_result_ack`  out  1  sequencer ready for a result.
- `out_data`  out  DATA_WIDTH  fib(n).
- `out_index`  out  DATA_WIDTH  `n` belonging to `out_data`.
- `out_last`  out  1  final item of the batch.
- `out_valid`  out  1  output item present.
- `out_ready`  in  1  downstream accepts the item.
- `busy`  out  1  batch in progress (state ≠ IDLE).
- `err`  out  1  sticky timeout flag; cleared when the next command is accepted.

## Operation

- `fib` handshakes: a transfer completes on a rising edge where en and ack are both 1.
  - Param channel: the sequencer holds `fib_param_en=1` and `fib_param_data` stable until the transfer completes.
  - Result channel: the sequencer holds `fib_result_ack=1` until the transfer completes.
- FSM states: IDLE, SEND, RECV, EMIT.
- IDLE:
  - `cmd_ready=1`.
  - On an accepted command with `cmd_count=0`: clear `err`, stay in IDLE, emit nothing.
  - On an accepted command with `cmd_count≠0`: latch `n=cmd_start` and `rem=cmd_count`, clear `err`, go to SEND.
- SEND:
  - `fib_param_en=1`, `fib_param_data=n`.
  - On param transfer: go to RECV.
- RECV:
  - `fib_result_ack=1`.
  - On result transfer: register `out_data=fib_result_data`, `out_index=n`, `out_last=(rem==1)`, set `out_valid=1`, go to EMIT.
- EMIT:
  - Hold all outputs stable while `out_ready=0`.
  - On `out_valid && out_ready`: drop `out_valid`.
  - If `rem==1`, go to IDLE; otherwise `n←n+1`, `rem←rem−1`, go to SEND.
- Arithmetic: `n+1` wraps modulo 2^DATA_WIDTH; `rem` never underflows.
- Timeout (only when `TIMEOUT≠0`):
  - A counter loads `TIMEOUT` on entry to SEND or RECV and decrements each cycle the handshake does not complete.
  - At 0 without completion: set `err`, drop `fib_param_en` / `fib_result_ack`, abandon the batch, return to IDLE. No `out_last` is emitted.
  - If the handshake completes in the same cycle the counter reaches 0, the handshake wins and no error is raised.
- Reset (`rst_n=0` at an edge), including mid-batch: go to IDLE and clear every register. Any in-flight `fib` handshake is withdrawn. `fib` shares the reset domain and is reset with the sequencer.

## Timing

- Reset values of outputs:
  - `cmd_ready=1`.
  - `fib_param_en=0`, `fib_param_data=0`, `fib_result_ack=0`.
  - `out_valid=0`, `out_data=0`, `out_index=0`, `out_last=0`.
  - `busy=0`, `err=0`.
- All outputs are registered, except `cmd_ready` and `busy`, which decode the state register.
- Command accepted at edge k: `fib_param_en=1` after edge k.
- Param transfer at edge p: `fib_result_ack=1` after edge p; `fib_param_en=0` in the same cycle.
- Result transfer at edge r: `out_valid=1` after edge r.
- Output transfer at edge e: next `fib_param_en=1` after edge e (not last item), or `cmd_ready=1` after edge e (last item).
- Minimum period is 3 cycles per item plus `fib` compute latency; there is no overlap between items.
- `cmd_ready=0` throughout a batch; commands presented during a batch wait.

## Test plan

- `cmd_start=0`, `cmd_count=7`, `out_ready=1` -> out (index, data) = (0,0) (1,1) (2,1) (3,2) (4,3) (5,5) (6,8); `out_last` only on index 6; `cmd_ready` returns high; `err=0`.
- `cmd_start=10`, `cmd_count=1` -> single item (10,55) with `out_last=1`.
- `cmd_start=20`, `cmd_count=3`, `out_ready` toggling 1-of-3 cycles -> 6765, 10946, 17711 in order, each held stable while stalled, and no new `fib_param_en` until the preceding output transfer.
- `cmd_count=0` -> command accepted in one cycle; no `fib_param_en`, no `out_valid`; `busy` stays 0.
- `fib` stub never asserts `fib_param_ack`, `TIMEOUT=1000` -> `fib_param_en` high exactly 1000 cycles, then `err=1`, IDLE, no output; the next command clears `err`.
- `rst_n=0` for one edge while in EMIT with `out_valid=1` -> next cycle all outputs at reset values; a new batch (start 4, count 2) yields (4,3) (5,5).
